// File: rtl/uart_rx_pkg.sv
// Shared types for the UART frame receiver: FSM state encoding
// and the legal oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  function automatic logic legal_prescale(input int p);
    return (p == PRESCALE_X8) ||
           (p == PRESCALE_X16) ||
           (p == PRESCALE_X32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and bit sampler for the UART receiver.
// UART_RX_MAJORITY_SAMPLE_EN selects 2-of-3 majority sampling.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  active,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_end,
  output logic                  bit_val
);

  localparam logic [PRESCALE_W-1:0] ONE = 1;

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic                  s_mid;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
  logic                  s_lo;
  logic                  s_hi;
`endif

  assign half    = pre_q >> 1;
  assign last    = pre_q - ONE;
  assign bit_end = active && (cnt == last);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
  assign bit_val = (s_lo & s_mid) |
                   (s_lo & s_hi) |
                   (s_mid & s_hi);
`else
  assign bit_val = s_mid;
`endif

  // Start-detect cycle is edge 0, so the count resumes at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      pre_q <= '0;
      s_mid <= 1'b1;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
      s_lo  <= 1'b1;
      s_hi  <= 1'b1;
`endif
    end else if (start) begin
      pre_q <= prescale;
      cnt   <= (prescale == ONE) ? '0 : ONE;
    end else if (active) begin
      cnt <= (cnt == last) ? '0 : cnt + ONE;
      if (cnt == half)
        s_mid <= rx;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
      if (cnt == half - ONE)
        s_lo <= rx;
      if (cnt == half + ONE)
        s_hi <= rx;
`endif
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start/data/parity/stop FSM and checks.
// Build option: UART_RX_MAJORITY_SAMPLE_EN (majority sampling).
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BONE = 1;

  rx_state_e             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic                  par_typ_q;
  logic                  start;
  logic                  active;
  logic                  bit_end;
  logic                  bit_val;

  assign start  = (state == IDLE) && !RX_IN;
  assign active = (state != IDLE);

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .active  (active),
    .rx      (RX_IN),
    .prescale(Prescale),
    .bit_end (bit_end),
    .bit_val (bit_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      par_typ_q  <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!RX_IN) begin
            state   <= START;
            PAR_ERR <= 1'b0;
            STP_ERR <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= bit_val ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + BONE;
            if (bit_idx == LAST_BIT) begin
              state     <= PAR_EN ? PARITY : STOP;
              par_typ_q <= PAR_TYP;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (bit_val != (^shreg ^ par_typ_q))
              PAR_ERR <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!bit_val) begin
              STP_ERR <= 1'b1;
            end else if (!PAR_ERR) begin
              Data_Valid <= 1'b1;
              P_DATA     <= shreg;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized frame-level checks for uart_rx_frame
// against a frame-outcome reference model.
module tb_uart_rx_frame;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [PW-1:0] Prescale;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_ERR;
  logic          STP_ERR;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int dv_q[$];
  int exp_dv[$];

  logic [DW-1:0] m_pdata   = '0;
  logic          m_par_err = 1'b0;
  logic          m_stp_err = 1'b0;

  logic [DW-1:0] rd;
  int            rp;
  logic          rpe;
  logic          rpt;
  logic          rbad;
  logic          rstop;

  uart_rx_frame #(
    .DATA_WIDTH(DW),
    .PRESCALE_W(PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (Data_Valid === 1'b1) dv_q.push_back(cyc);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h",
             tag, got, exp);
    end
  endtask

  // Parity bit that makes the total ones count even or odd.
  function automatic logic par_bit(input logic [DW-1:0] d,
                                   input logic odd);
    int ones;
    ones = $countones(d);
    if (odd) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic int rand_p();
    case ($urandom_range(0, 2))
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  task automatic frame(input logic [DW-1:0] d,
                       input int p,
                       input logic pe,
                       input logic pt,
                       input logic bad_par,
                       input logic stop,
                       input int gap,
                       input int glitch_bit,
                       input int abort_at,
                       input bit scramble);
    logic bits[$];
    int   n;
    int   t0;
    int   nb;
    logic v;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par_bit(d, pt) ^ bad_par);
    bits.push_back(stop);
    nb = bits.size();
    Prescale = PW'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    n  = 0;
    t0 = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        if (n == 0) t0 = cyc;
        if (n == abort_at) return;
        if (n == 1) begin
          check("par_err_clear", PAR_ERR, 0);
          check("stp_err_clear", STP_ERR, 0);
          if (scramble) Prescale = PW'(rand_p());
        end
        RX_IN = bits[b] ^ ((b == glitch_bit) && (j == p / 2));
        n++;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
    m_par_err = pe && bad_par;
    m_stp_err = !stop;
    v = !m_par_err && stop;
    if (v) begin
      m_pdata = d;
      exp_dv.push_back(t0 + nb * p);
    end
  endtask

  task automatic verify(input string tag);
    #1;
    check({tag, "_dv_count"}, dv_q.size(), exp_dv.size());
    if (dv_q.size() == exp_dv.size())
      foreach (exp_dv[i])
        check({tag, "_dv_cycle"}, dv_q[i], exp_dv[i]);
    check({tag, "_p_data"}, P_DATA, m_pdata);
    check({tag, "_par_err"}, PAR_ERR, m_par_err);
    check({tag, "_stp_err"}, STP_ERR, m_stp_err);
    dv_q.delete();
    exp_dv.delete();
  endtask

  initial begin
    reset    = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = PW'(8);
    repeat (2) @(negedge clk);
    #1;
    check("rst_p_data", P_DATA, m_pdata);
    check("rst_dv", Data_Valid, 0);
    check("rst_par_err", PAR_ERR, m_par_err);
    check("rst_stp_err", STP_ERR, m_stp_err);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    frame(8'hA5, 8, 0, 0, 0, 1, 3, -1, -1, 0);
    verify("s1");
    frame(8'h3C, 16, 1, 1, 0, 1, 3, -1, -1, 0);
    verify("s2_ok");
    frame(8'h3C, 16, 1, 1, 1, 1, 3, -1, -1, 0);
    verify("s2_bad_par");
    frame(8'h81, 32, 0, 0, 0, 0, 3, -1, -1, 0);
    verify("s3_stop");
    frame(8'h55, 8, 0, 0, 0, 1, 0, -1, -1, 0);
    frame(8'hAA, 8, 0, 0, 0, 1, 3, -1, -1, 0);
    verify("s5_b2b");

    Prescale = PW'(16);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      RX_IN = (n < 3) ? 1'b0 : 1'b1;
    end
    verify("s4_glitch");
    frame(8'h5A, 16, 0, 0, 0, 1, 3, -1, -1, 0);
    verify("s4_after");

    frame(8'hC3, 8, 0, 0, 0, 1, 0, -1, 40, 0);
    reset = 1'b0;
    m_pdata   = '0;
    m_par_err = 1'b0;
    m_stp_err = 1'b0;
    exp_dv.delete();
    #1;
    check("s6_dv", Data_Valid, 0);
    verify("s6_reset");
    RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'h12, 8, 0, 0, 0, 1, 3, -1, -1, 0);
    verify("s6_after");

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    frame(8'h6B, 16, 0, 0, 0, 1, 3, 4, -1, 0);
    verify("maj_glitch");
`endif

    for (int k = 0; k < 12; k++) begin
      rd    = DW'($urandom);
      rp    = rand_p();
      rpe   = 1'($urandom_range(0, 1));
      rpt   = 1'($urandom_range(0, 1));
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 3) != 0);
      frame(rd, rp, rpe, rpt, rbad, rstop,
            $urandom_range(2, 5), -1, -1, 1);
      verify("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
